// File: rtl/sig_edge_filter.sv
// sig_edge_filter: glitch filter on a synchronized level with edge pulses and an optional edge counter (SIG_EDGE_FILTER_CNT_EN)
module sig_edge_filter #(
    parameter int   FILTER_LEN  = 4,
    parameter int   CNT_WIDTH   = 8,
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic                 i_Clk,
    input  logic                 i_aReset_N,
    input  logic                 i_cSig,
    input  logic                 i_cCntClr,
    output logic                 o_cLevel,
    output logic                 o_cRise,
    output logic                 o_cFall,
    output logic [CNT_WIDTH-1:0] o_cEdgeCnt
);
    typedef enum logic {STABLE, QUALIFY} state_t;
    localparam logic [8:0] FilterLen = 9'(FILTER_LEN);
    state_t     state;
    logic [7:0] qualCnt;
    logic [8:0] qualNext;
    logic       acceptEdge;
    // A new level is accepted once FILTER_LEN consecutive samples disagree with the current one
    always_comb begin
        qualNext   = {1'b0, qualCnt} + 9'd1;
        acceptEdge = (i_cSig != o_cLevel) && ((state == QUALIFY) ? (qualNext == FilterLen) : (FilterLen == 9'd1));
    end
    // Qualification FSM with registered level and edge pulses
    always_ff @(posedge i_Clk or negedge i_aReset_N) begin
        if (!i_aReset_N) begin
            state    <= STABLE;
            qualCnt  <= '0;
            o_cLevel <= RESET_VALUE;
            o_cRise  <= 1'b0;
            o_cFall  <= 1'b0;
        end else begin
            o_cRise <= acceptEdge && i_cSig;
            o_cFall <= acceptEdge && !i_cSig;
            if (acceptEdge) begin
                o_cLevel <= i_cSig;
                state    <= STABLE;
                qualCnt  <= '0;
            end else if (i_cSig == o_cLevel) begin
                state   <= STABLE;
                qualCnt <= '0;
            end else begin
                state   <= QUALIFY;
                qualCnt <= qualNext[7:0];
            end
        end
    end
`ifdef SIG_EDGE_FILTER_CNT_EN
    logic [CNT_WIDTH-1:0] edgeCnt;
    // Wrapping edge counter; a clear in the same cycle as an edge wins
    always_ff @(posedge i_Clk or negedge i_aReset_N) begin
        if (!i_aReset_N)
            edgeCnt <= '0;
        else if (i_cCntClr)
            edgeCnt <= '0;
        else if (acceptEdge)
            edgeCnt <= edgeCnt + CNT_WIDTH'(1);
    end
    assign o_cEdgeCnt = edgeCnt;
`else
    assign o_cEdgeCnt = {CNT_WIDTH{i_cCntClr & 1'b0}};
`endif
endmodule
